// File: rtl/fetch_prefetch_pkg.sv
// Shared widths and the queue entry layout for the fetch/prefetch stage.
package fetch_prefetch_pkg;

  localparam int WORD = 32;
  localparam int ADDR = 16;

  typedef struct packed {
    logic [ADDR-1:0] pc;
    logic [WORD-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_fifo.sv
// Synchronous FIFO with flush, occupancy count and a head-of-queue data port.
module fetch_queue_fifo #(
  parameter int WIDTH = 48,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         push_data,
  output logic [WIDTH-1:0]         head_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW:0]      count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + (PW+1)'(push) - (PW+1)'(pop);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; count gates validity, so stale words are never observed.
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= push_data;
  end

  assign head_data = mem_q[rd_ptr_q];
  assign count     = count_q;

endmodule

// File: rtl/fetch_prefetch.sv
// Fetch stage: PC, one in-flight memory read, credit-based issue and a prefetch queue.
module fetch_prefetch
  import fetch_prefetch_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter logic [ADDR-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall_i,
  input  logic            branch_i,
  input  logic [ADDR-1:0] branch_addr_i,
  input  logic [WORD-1:0] inst_i,
  output logic [ADDR-1:0] mem_o,
  output logic            v_o,
  output logic [WORD-1:0] inst_o,
  output logic [ADDR-1:0] pc_o,
  output logic            stall_o
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [ADDR-1:0] pc_q, pc_d;
  logic [ADDR-1:0] req_pc_q, req_pc_d;
  logic            req_v_q, req_v_d;

  logic [CW-1:0]   count;
  logic [CW:0]     credit;
  fetch_entry_t    head, push_entry;
  logic            valid, pop, push, issue;

  always_comb begin
    valid      = (count != '0);
    pop        = valid & ~stall_i & ~branch_i;
    push       = req_v_q & ~branch_i;
    // Slots already claimed once this cycle's pop retires: queued plus in flight.
    credit     = {1'b0, count} + (CW+1)'(req_v_q) - (CW+1)'(pop);
    issue      = branch_i | (credit < (CW+1)'(DEPTH));
    mem_o      = branch_i ? branch_addr_i : pc_q;
    req_v_d    = issue;
    req_pc_d   = issue ? mem_o : req_pc_q;
    pc_d       = issue ? mem_o + 1'b1 : pc_q;
    push_entry = '{pc: req_pc_q, inst: inst_i};
    v_o        = valid;
    inst_o     = valid ? head.inst : '0;
    pc_o       = valid ? head.pc   : '0;
    stall_o    = ~issue;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q     <= RESET_PC;
      req_v_q  <= 1'b0;
      req_pc_q <= '0;
    end else begin
      pc_q     <= pc_d;
      req_v_q  <= req_v_d;
      req_pc_q <= req_pc_d;
    end
  end

  fetch_queue_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk       (clk),
    .reset     (reset),
    .flush     (branch_i),
    .push      (push),
    .pop       (pop),
    .push_data (push_entry),
    .head_data (head),
    .count     (count)
  );

endmodule
